// File: rtl/mcpu_pkg.sv
`default_nettype none
// ============================================================================
// mcpu_pkg : shared encodings for the multicycle MIPS control sequencer
// Rev 1.0
// ============================================================================
package mcpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [2:0] OP_I_GRP = 3'b001;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] ALUOP_ADDR = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_RI   = 2'b10;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;
  localparam logic [1:0] PCSRC_JR  = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl32_decode.sv
`default_nettype none
// ============================================================================
// mc_decode32 : combinational instruction-class decode from opcode/funct
// Rev 1.0
// ============================================================================
module mc_decode32
  import mcpu_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic       o_is_r,
  output logic       o_is_i,
  output logic       o_is_lw,
  output logic       o_is_sw,
  output logic       o_is_beq,
  output logic       o_is_bne,
  output logic       o_is_j,
  output logic       o_is_jal,
  output logic       o_is_jr,
  output logic       o_is_shift,
  output logic       o_is_illegal
);

  always_comb begin
    o_is_r       = (i_op == OP_R);
    o_is_i       = (i_op[5:3] == OP_I_GRP);
    o_is_lw      = (i_op == OP_LW);
    o_is_sw      = (i_op == OP_SW);
    o_is_beq     = (i_op == OP_BEQ);
    o_is_bne     = (i_op == OP_BNE);
    o_is_j       = (i_op == OP_J);
    o_is_jal     = (i_op == OP_JAL);
    o_is_jr      = o_is_r && (i_funct == FUNCT_JR);
    o_is_shift   = o_is_r && (i_funct[5:3] == 3'b000);
    o_is_illegal = !(o_is_r || o_is_i || o_is_lw || o_is_sw || o_is_beq ||
                     o_is_bne || o_is_j || o_is_jal);
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl32.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl32 : FETCH/DECODE/EXEC/MEM/WB sequencer and instret counter
// Rev 1.0
// ============================================================================
module multicycle_ctrl32
  import mcpu_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int JAL_REG = 31
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       Function_opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             IR_write,
  output logic             PC_write,
  output logic [1:0]       PC_src,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             I_format,
  output logic             Sftmd,
  output logic             Jr,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic             MemtoReg,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  // The jal destination is hard-wired on the datapath's RegDst=2 leg.
  if (JAL_REG != 31) begin : g_jal_reg_alt
  end

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op;
  logic [5:0]       r_funct;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic [5:0]       w_op;
  logic [5:0]       w_funct;

  logic w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq, w_is_bne;
  logic w_is_j, w_is_jal, w_is_jr, w_is_shift, w_is_illegal;

  // DECODE sees the live IR; later phases use the copy latched on leaving DECODE.
  assign w_op    = (r_state == S_DECODE) ? opcode          : r_op;
  assign w_funct = (r_state == S_DECODE) ? Function_opcode : r_funct;

  mc_decode32 u_decode (
    .i_op         (w_op),
    .i_funct      (w_funct),
    .o_is_r       (w_is_r),
    .o_is_i       (w_is_i),
    .o_is_lw      (w_is_lw),
    .o_is_sw      (w_is_sw),
    .o_is_beq     (w_is_beq),
    .o_is_bne     (w_is_bne),
    .o_is_j       (w_is_j),
    .o_is_jal     (w_is_jal),
    .o_is_jr      (w_is_jr),
    .o_is_shift   (w_is_shift),
    .o_is_illegal (w_is_illegal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_funct   <= '0;
      r_instret <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_op    <= opcode;
        r_funct <= Function_opcode;
      end
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret = r_instret;

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    mem_req  = 1'b0;
    MemWrite = 1'b0;
    IR_write = 1'b0;
    PC_write = 1'b0;
    PC_src   = PCSRC_SEQ;
    ALUOp    = ALUOP_ADDR;
    ALUSrc   = 1'b0;
    I_format = 1'b0;
    Sftmd    = 1'b0;
    Jr       = 1'b0;
    RegWrite = 1'b0;
    RegDst   = REGDST_RT;
    MemtoReg = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IR_write = 1'b1;
          PC_write = 1'b1;
          PC_src   = PCSRC_SEQ;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_is_j || w_is_jal) begin
          PC_write = 1'b1;
          PC_src   = PCSRC_JMP;
          RegWrite = w_is_jal;
          RegDst   = w_is_jal ? REGDST_RA : REGDST_RT;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_illegal) begin
          illegal  = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_r) begin
          ALUOp = ALUOP_RI;
          Sftmd = w_is_shift;
          Jr    = w_is_jr;
          if (w_is_jr) begin
            PC_write = 1'b1;
            PC_src   = PCSRC_JR;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_is_i) begin
          ALUOp    = ALUOP_RI;
          ALUSrc   = 1'b1;
          I_format = 1'b1;
          w_next   = S_WB;
        end else if (w_is_lw || w_is_sw) begin
          ALUOp  = ALUOP_ADDR;
          ALUSrc = 1'b1;
          w_next = S_MEM;
        end else begin
          ALUOp    = ALUOP_BR;
          PC_src   = PCSRC_BR;
          PC_write = w_is_beq ? Zero : !Zero;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        MemWrite = w_is_sw;
        ALUOp    = ALUOP_ADDR;
        ALUSrc   = 1'b1;
        if (mem_ready) begin
          w_retire = w_is_sw;
          w_next   = w_is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = w_is_r ? REGDST_RD : REGDST_RT;
        MemtoReg = w_is_lw;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
